// File: rtl/mjpg_pkg.sv
// mjpg_pkg: widths shared by the bitstream packer and the upstream merge logic
package mjpg_pkg;
  localparam int BS_LEN_W   = 6;
  localparam int BS_DATA_W  = 32;
  localparam int BS_MAX_LEN = 32;
  localparam int BS_ACC_W   = 2 * BS_DATA_W;
  typedef logic [BS_LEN_W-1:0]  bs_len_t;
  typedef logic [BS_DATA_W-1:0] bs_data_t;
  typedef logic [BS_ACC_W-1:0]  bs_acc_t;
endpackage

// File: rtl/bitstream_packer_if.sv
// bitstream_packer_if: code input and packed word output of the bitstream packer
interface bitstream_packer_if;
  import mjpg_pkg::*;
  bs_len_t    ilength;
  bs_data_t   idata;
  logic [2:0] rest;
  logic       ovalid;
  bs_data_t   odata;
  modport master (output ilength, idata, input rest, ovalid, odata);
  modport slave  (input ilength, idata, output rest, ovalid, odata);
endinterface

// File: rtl/bitstream_packer_bit_aligner.sv
// bit_aligner: masks the code to its clamped length and places it right after fill buffered bits
module bit_aligner
  import mjpg_pkg::*;
(
  input  bs_len_t  fill,
  input  bs_len_t  ilength,
  input  bs_data_t idata,
  output bs_len_t  len,
  output bs_acc_t  placed
);
  bs_data_t masked;
  // clamp illegal lengths, drop don't-care bits, left-justify then step past the buffered bits
  always_comb begin
    len    = (ilength > BS_LEN_W'(BS_MAX_LEN)) ? BS_LEN_W'(BS_MAX_LEN) : ilength;
    masked = idata & ~({BS_DATA_W{1'b1}} << len);
    placed = ({{BS_DATA_W{1'b0}}, masked} << (7'd64 - {1'b0, len})) >> fill;
  end
endmodule

// File: rtl/bitstream_packer.sv
// bitstream_packer: packs variable-length codes MSB-first into 32-bit words
module bitstream_packer
  import mjpg_pkg::*;
(
  input logic               clk,
  input logic               rst,
  bitstream_packer_if.slave bs
);
  bs_len_t  fill_q, fill_d, len, n;
  bs_acc_t  acc_q, acc_d, placed, merged;
  logic     ovalid_q, ovalid_d, emit;
  bs_data_t odata_q, odata_d;
  bit_aligner u_align (
    .fill    (fill_q),
    .ilength (bs.ilength),
    .idata   (bs.idata),
    .len     (len),
    .placed  (placed)
  );
  // merge new bits under the buffer and peel off the oldest word once 32 bits are present
  always_comb begin
    n        = fill_q + len;
    merged   = acc_q | placed;
    emit     = n >= BS_LEN_W'(BS_DATA_W);
    fill_d   = emit ? n - BS_LEN_W'(BS_DATA_W) : n;
    acc_d    = emit ? {merged[BS_DATA_W-1:0], {BS_DATA_W{1'b0}}} : merged;
    ovalid_d = emit;
    odata_d  = emit ? merged[BS_ACC_W-1:BS_DATA_W] : odata_q;
  end
  // state and registered outputs; rst is active-low and asynchronous
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q   <= '0;
      acc_q    <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      fill_q   <= fill_d;
      acc_q    <= acc_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end
  assign bs.ovalid = ovalid_q;
  assign bs.odata  = odata_q;
  assign bs.rest   = 3'd0 - fill_q[2:0];
endmodule

// File: tb/tb_bitstream_packer.sv
// tb_bitstream_packer: bit-queue model plus directed vectors for bitstream_packer
module tb_bitstream_packer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   q[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  int          ml;
  bitstream_packer_if bs();
  bitstream_packer dut (.clk(clk), .rst(rst), .bs(bs));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: the stream is a plain queue of bits, oldest first
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
    end else begin
      ml = (bs.ilength > 32) ? 32 : int'(bs.ilength);
      for (int i = ml - 1; i >= 0; i--) q.push_back(bs.idata[i]);
      exp_valid = 1'b0;
      if (q.size() >= 32) begin
        for (int i = 31; i >= 0; i--) exp_data[i] = q.pop_front();
        exp_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ovalid", {31'd0, bs.ovalid}, {31'd0, exp_valid});
      chk("odata", bs.odata, exp_data);
      chk("rest", {29'd0, bs.rest}, 32'((8 - q.size() % 8) % 8));
    end
  end

  task automatic step(input int len, input logic [31:0] d);
    bs.ilength = 6'(len);
    bs.idata   = d;
    @(posedge clk);
    #1;
    bs.ilength = '0;
    bs.idata   = $urandom;
  endtask

  initial begin
    bs.ilength = '0;
    bs.idata   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("reset_ovalid", {31'd0, bs.ovalid}, 32'd0);
    chk("reset_odata", bs.odata, 32'd0);
    chk("reset_rest", {29'd0, bs.rest}, 32'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    step(8, 32'hABCDEF12);
    step(8, 32'h55555534);
    step(8, 32'hFFFFFF56);
    chk("bytes_pending", {31'd0, bs.ovalid}, 32'd0);
    step(8, 32'h00000078);
    chk("bytes_valid", {31'd0, bs.ovalid}, 32'd1);
    chk("bytes_word", bs.odata, 32'h12345678);
    chk("bytes_model", exp_data, 32'h12345678);
    step(3, 32'hFFFFFFFD);
    chk("pad_rest5", {29'd0, bs.rest}, 32'd5);
    step(5, 32'h000000FF);
    chk("pad_rest0", {29'd0, bs.rest}, 32'd0);
    step(8, 32'h000000FF);
    step(8, 32'h000000D8);
    step(8, 32'h00000000);
    chk("pad_word", bs.odata, 32'hBFFFD800);
    chk("pad_model", exp_data, 32'hBFFFD800);
    for (int i = 0; i < 10; i++) begin
      step(32, 32'hA0000000 + 32'(i));
      chk("thru_valid", {31'd0, bs.ovalid}, 32'd1);
      chk("thru_word", bs.odata, 32'hA0000000 + 32'(i));
    end
    step(20, 32'hFFFABCDE);
    step(20, 32'h00012345);
    chk("straddle_word", bs.odata, 32'hABCDE123);
    chk("straddle_rest", {29'd0, bs.rest}, 32'd0);
    step(24, 32'h00000000);
    chk("straddle_tail", bs.odata, 32'h45000000);
    chk("straddle_model", exp_data, 32'h45000000);
    step(4, 32'hFFFFFFF5);
    chk("mask_rest", {29'd0, bs.rest}, 32'd4);
    repeat (20) begin
      @(negedge clk);
      bs.idata = $urandom;
    end
    @(posedge clk); #1;
    chk("zero_rest", {29'd0, bs.rest}, 32'd4);
    step(28, 32'hF0ABCDEF);
    chk("mask_word", bs.odata, 32'h50ABCDEF);
    step(40, 32'hDEADBEEF);
    chk("clamp_word", bs.odata, 32'hDEADBEEF);
    step(8, 32'h000000AA);
    step(5, 32'h0000001F);
    chk("pre_reset_rest", {29'd0, bs.rest}, 32'd3);
    step(32, 32'h11111111);
    #2 rst = 1'b0;
    #1;
    chk("async_ovalid", {31'd0, bs.ovalid}, 32'd0);
    chk("async_odata", bs.odata, 32'd0);
    chk("async_rest", {29'd0, bs.rest}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    step(8, 32'h000000FF);
    step(8, 32'h000000D9);
    step(8, 32'h000000FF);
    step(8, 32'h000000D8);
    chk("post_reset_word", bs.odata, 32'hFFD9FFD8);
    chk("post_reset_model", exp_data, 32'hFFD9FFD8);
    repeat (200) step($urandom_range(0, 32), $urandom);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
